// File: rtl/mult_rr_sched_if.sv
// Bundle for the scheduler's request, multiplier and response buses.
// slave is the scheduler's view; master is the clients/multiplier/consumer side.
interface mult_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 15
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;

    logic                      mul_valid;
    logic [DATA_W-1:0]         mul_a;
    logic [DATA_W-1:0]         mul_b;
    logic [2*DATA_W-1:0]       mul_p;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [2*DATA_W-1:0]       rsp_data;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, rsp_ready,
        output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, rsp_ready,
        input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one pipelined multiplier, with a credit-protected
// response FIFO. Define MULT_RR_SCHED_STATS_EN to add issue/stall counters.
module mult_rr_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 15,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    mult_rr_sched_if.slave bus
`ifdef MULT_RR_SCHED_STATS_EN
    ,
    output logic [31:0]    stat_issue_cnt,
    output logic [31:0]    stat_stall_cnt
`endif
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int P_W   = 2 * DATA_W;

    logic [ID_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  credit_used;
    logic              pop, issue_ok, grant;
    logic [ID_W-1:0]   grant_id;
    logic [DATA_W-1:0] grant_a, grant_b;
    logic [ID_W:0]     scan_idx;

    logic              mul_valid_q;
    logic [DATA_W-1:0] mul_a_q, mul_b_q;
    logic [ID_W-1:0]   iss_id;

    logic              tag_v  [MUL_LAT];
    logic [ID_W-1:0]   tag_id [MUL_LAT];

    logic [ID_W-1:0]   fifo_id   [FIFO_DEPTH];
    logic [P_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_wr, fifo_empty;
    logic [ID_W-1:0]   last_id;
    logic [P_W-1:0]    last_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A same-cycle pop returns its credit immediately, hence rsp_ready -> req_ready.
    assign fifo_empty  = (fifo_cnt == '0);
    assign pop         = !fifo_empty && bus.rsp_ready;
    assign credit_used = outstanding - CNT_W'(pop);
    assign issue_ok    = (credit_used < CNT_W'(FIFO_DEPTH));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        grant    = 1'b0;
        grant_id = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            if (!grant && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                grant    = 1'b1;
                grant_id = scan_idx[ID_W-1:0];
            end
        end
        if (!issue_ok) grant = 1'b0;
    end

    always_comb begin
        bus.req_ready = '0;
        grant_a       = '0;
        grant_b       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                bus.req_ready[i] = grant;
                grant_a          = bus.req_a[i*DATA_W +: DATA_W];
                grant_b          = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            iss_id      <= '0;
            rr_ptr      <= '0;
        end else begin
            mul_valid_q <= grant;
            mul_a_q     <= grant ? grant_a : '0;
            mul_b_q     <= grant ? grant_b : '0;
            iss_id      <= grant_id;
            if (grant) rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    assign bus.mul_valid = mul_valid_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;

    // Tag pipeline tracks which requester owns the product emerging from the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= mul_valid_q;
            tag_id[0] <= iss_id;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign fifo_wr = tag_v[MUL_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (grant && !pop) begin
            outstanding <= outstanding + CNT_W'(1);
        end else if (!grant && pop) begin
            outstanding <= outstanding - CNT_W'(1);
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_id[wr_ptr]   <= tag_id[MUL_LAT-1];
            fifo_data[wr_ptr] <= bus.mul_p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            last_id   <= '0;
            last_data <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr    <= ptr_inc(rd_ptr);
                last_id   <= fifo_id[rd_ptr];
                last_data <= fifo_data[rd_ptr];
            end
            if (fifo_wr && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (!fifo_wr && pop) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    // An empty FIFO keeps presenting the most recently popped response.
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_id    = fifo_empty ? last_id   : fifo_id[rd_ptr];
    assign bus.rsp_data  = fifo_empty ? last_data : fifo_data[rd_ptr];

    a_no_full_write: assert property (@(posedge clk) disable iff (rst)
        !(fifo_wr && (fifo_cnt == CNT_W'(FIFO_DEPTH)) && !pop));

`ifdef MULT_RR_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issue_cnt <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (grant && (stat_issue_cnt != '1)) stat_issue_cnt <= stat_issue_cnt + 32'd1;
            if ((|bus.req_valid) && !issue_ok && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched: directed scenarios plus a randomized run
// against a queue-based reference model. Stats checks follow MULT_RR_SCHED_STATS_EN.
module tb_mult_rr_sched;
    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 15;
    localparam int MUL_LAT    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = $clog2(NUM_REQ);
    localparam int P_W        = 2 * DATA_W;
    localparam logic [DATA_W-1:0] OP_MAX = '1;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  data;
        int              avail;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mult_rr_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

`ifdef MULT_RR_SCHED_STATS_EN
    logic [31:0] stat_issue_cnt, stat_stall_cnt;
`endif

    mult_rr_sched #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MULT_RR_SCHED_STATS_EN
        ,
        .stat_issue_cnt(stat_issue_cnt),
        .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External multiplier: product appears MUL_LAT cycles after the operands are sampled.
    logic [P_W-1:0] mul_pipe [MUL_LAT];
    always @(posedge clk) begin
        mul_pipe[0] <= P_W'(bus.mul_a) * P_W'(bus.mul_b);
        for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
    assign bus.mul_p = mul_pipe[MUL_LAT-1];

    function automatic logic [P_W-1:0] prod(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return P_W'(a) * P_W'(b);
    endfunction

    function automatic logic [DATA_W-1:0] op_a(input int i);
        return bus.req_a[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] op_b(input int i);
        return bus.req_b[i*DATA_W +: DATA_W];
    endfunction

    task automatic set_op(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bus.req_a[i*DATA_W +: DATA_W] = a;
        bus.req_b[i*DATA_W +: DATA_W] = b;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] rv, input logic rr);
        bus.req_valid = rv;
        bus.rsp_ready = rr;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, 1'b0);
        adv();
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'($urandom), DATA_W'($urandom));
        drive('0, 1'b0);
        adv();
        adv();
        n_cmp++; if (bus.mul_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mul_valid: got %b want 0", bus.mul_valid); end
        n_cmp++; if (bus.mul_a !== '0 || bus.mul_b !== '0) begin n_bad++; $display("FAIL reset_mul_ab: got %h/%h want 0/0", bus.mul_a, bus.mul_b); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== '0 || bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp: got %0d/%h want 0/0", bus.rsp_id, bus.rsp_data); end
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
`ifdef MULT_RR_SCHED_STATS_EN
        n_cmp++; if (stat_issue_cnt !== 32'd0 || stat_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_issue_cnt, stat_stall_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_op(2, 15'd3, 15'd5);
        drive(4'b0100, 1'b1);
        n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_grant: got %b want 0100", bus.req_ready); end
        adv();
        drive('0, 1'b1);
        n_cmp++; if (bus.mul_valid !== 1'b1 || bus.mul_a !== 15'd3 || bus.mul_b !== 15'd5) begin
            n_bad++; $display("FAIL single_issue: got v=%b a=%0d b=%0d want v=1 a=3 b=5", bus.mul_valid, bus.mul_a, bus.mul_b); end
        for (int k = 2; k < 4; k++) begin
            adv();
            drive('0, 1'b1);
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_rsp: cycle %0d got %b want 0", k, bus.rsp_valid); end
        end
        adv();
        drive('0, 1'b1);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 30'd15) begin
            n_bad++; $display("FAIL single_rsp: got v=%b id=%0d d=%0d want v=1 id=2 d=15", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        adv();
        drive('0, 1'b1);
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 30'd15) begin
            n_bad++; $display("FAIL single_hold: got v=%b id=%0d d=%0d want v=0 id=2 d=15", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
    endtask

    task automatic test_round_robin();
        rsp_t q[$];
        rsp_t e;
        logic [NUM_REQ-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'($urandom), DATA_W'($urandom));
            drive((k < 16) ? 4'b1111 : 4'b0000, 1'b1);
            if (k < 16) begin
                exp_rdy = NUM_REQ'(1 << (k % NUM_REQ));
                n_cmp++; if (bus.req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant: cycle %0d got %b want %b", k, bus.req_ready, exp_rdy); end
                e.id = ID_W'(k % NUM_REQ);
                e.data = prod(op_a(k % NUM_REQ), op_b(k % NUM_REQ));
                e.avail = k + MUL_LAT + 2;
                q.push_back(e);
            end
            if (k >= 1 && k <= 16) begin
                n_cmp++; if (bus.mul_valid !== 1'b1) begin n_bad++; $display("FAIL rr_bubble: cycle %0d mul_valid got %b want 1", k, bus.mul_valid); end
            end
            if (k >= 4) begin
                e = q.pop_front();
                n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_data !== e.data) begin
                    n_bad++; $display("FAIL rr_rsp: cycle %0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, e.id, e.data); end
            end
            adv();
        end
    endtask

    task automatic test_backpressure();
        logic [P_W-1:0] exp_p;
        int seen;
        do_reset();
        set_op(0, DATA_W'($urandom), DATA_W'($urandom));
        exp_p = prod(op_a(0), op_b(0));
        for (int k = 0; k < 14; k++) begin
            drive(4'b0001, 1'b0);
            n_cmp++; if (bus.req_ready !== ((k < FIFO_DEPTH) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL bp_grant: cycle %0d got %b want %b", k, bus.req_ready, (k < FIFO_DEPTH) ? 4'b0001 : 4'b0000); end
            if (k >= 4) begin
                n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_data !== exp_p) begin
                    n_bad++; $display("FAIL bp_hold: cycle %0d got v=%b id=%0d d=%h want v=1 id=0 d=%h", k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_p); end
            end
            adv();
        end
        drive(4'b0001, 1'b1);
`ifdef MULT_RR_SCHED_STATS_EN
        n_cmp++; if (stat_issue_cnt !== 32'd4 || stat_stall_cnt !== 32'd10) begin
            n_bad++; $display("FAIL bp_stats: got issue=%0d stall=%0d want issue=4 stall=10", stat_issue_cnt, stat_stall_cnt); end
`endif
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_release_grant: got %b want 0001", bus.req_ready); end
        adv();
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            drive('0, 1'b1);
            if (bus.rsp_valid === 1'b1) seen++;
            adv();
        end
        n_cmp++; if (seen !== 4) begin n_bad++; $display("FAIL bp_drain: got %0d responses want 4", seen); end
    endtask

    task automatic test_boundary();
        do_reset();
        set_op(1, OP_MAX, OP_MAX);
        drive(4'b0010, 1'b1);
        adv();
        set_op(3, 15'd0, OP_MAX);
        drive(4'b1000, 1'b1);
        adv();
        drive('0, 1'b1);
        adv();
        drive('0, 1'b1);
        adv();
        drive('0, 1'b1);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 30'h3FFF0001) begin
            n_bad++; $display("FAIL bnd_max: got v=%b id=%0d d=%h want v=1 id=1 d=3fff0001", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        adv();
        drive('0, 1'b1);
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 || bus.rsp_data !== 30'h0) begin
            n_bad++; $display("FAIL bnd_zero: got v=%b id=%0d d=%h want v=1 id=3 d=0", bus.rsp_valid, bus.rsp_id, bus.rsp_data); end
        adv();
    endtask

    task automatic test_reset_midflight();
        int seen;
        logic [NUM_REQ-1:0] exp_rdy;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_op(k, DATA_W'(k + 2), DATA_W'(k + 7));
            drive(4'b0111, 1'b1);
            exp_rdy = NUM_REQ'(1 << k);
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_bad++; $display("FAIL rst_pre_grant: cycle %0d got %b want %b", k, bus.req_ready, exp_rdy); end
            adv();
        end
        drive('0, 1'b1);
        adv();
        rst = 1'b1;
        drive('0, 1'b1);
        adv();
        rst = 1'b0;
        drive('0, 1'b1);
        n_cmp++; if (bus.rsp_id !== '0 || bus.rsp_data !== '0) begin
            n_bad++; $display("FAIL rst_mid_rsp: got id=%0d d=%h want 0/0", bus.rsp_id, bus.rsp_data); end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            drive('0, 1'b1);
            if (bus.rsp_valid !== 1'b0) seen++;
            adv();
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_mid_discard: got %0d valid cycles want 0", seen); end
        drive(4'b1010, 1'b1);
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL rst_mid_ptr: got %b want 0010", bus.req_ready); end
        adv();
        drive('0, 1'b1);
    endtask

    task automatic test_random();
        rsp_t               q[$];
        rsp_t               e;
        int                 ptr, outstanding, g, idx;
        logic [ID_W-1:0]    last_id, exp_id;
        logic [P_W-1:0]     last_data, exp_data;
        logic               m_mv, rr, head_vis, pop, ok;
        logic [DATA_W-1:0]  m_ma, m_mb;
        logic [NUM_REQ-1:0] rv, exp_rdy;
        ptr = 0; outstanding = 0;
        last_id = '0; last_data = '0;
        m_mv = 1'b0; m_ma = '0; m_mb = '0;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) set_op(i, DATA_W'($urandom), DATA_W'($urandom));
            rv = NUM_REQ'($urandom);
            rr = ($urandom_range(0, 9) < 7);
            drive(rv, rr);
            head_vis = (q.size() > 0) && (q[0].avail <= cyc);
            pop = head_vis && rr;
            ok = (outstanding - (pop ? 1 : 0)) < FIFO_DEPTH;
            g = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (ptr + k) % NUM_REQ;
                if (ok && g < 0 && rv[idx]) g = idx;
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            exp_id = last_id;
            exp_data = last_data;
            if (head_vis) begin
                exp_id = q[0].id;
                exp_data = q[0].data;
            end
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_grant: cycle %0d got %b want %b", cyc, bus.req_ready, exp_rdy); end
            n_cmp++; if (bus.rsp_valid !== head_vis || bus.rsp_id !== exp_id || bus.rsp_data !== exp_data) begin
                n_bad++; $display("FAIL rand_rsp: cycle %0d got v=%b id=%0d d=%h want v=%b id=%0d d=%h", cyc, bus.rsp_valid, bus.rsp_id, bus.rsp_data, head_vis, exp_id, exp_data); end
            n_cmp++; if (bus.mul_valid !== m_mv || bus.mul_a !== m_ma || bus.mul_b !== m_mb) begin
                n_bad++; $display("FAIL rand_issue: cycle %0d got v=%b a=%h b=%h want v=%b a=%h b=%h", cyc, bus.mul_valid, bus.mul_a, bus.mul_b, m_mv, m_ma, m_mb); end
            if (pop) begin
                e = q.pop_front();
                last_id = e.id;
                last_data = e.data;
                outstanding--;
            end
            m_mv = (g >= 0);
            m_ma = '0;
            m_mb = '0;
            if (g >= 0) begin
                m_ma = op_a(g);
                m_mb = op_b(g);
                e.id = ID_W'(g);
                e.data = prod(op_a(g), op_b(g));
                e.avail = cyc + MUL_LAT + 2;
                q.push_back(e);
                outstanding++;
                ptr = (g + 1) % NUM_REQ;
            end
            adv();
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_boundary();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_rr_sched.md
Name: mult_rr_sched

Overview:
- Round-robin scheduler that shares one external pipelined DATA_W x DATA_W multiplier among NUM_REQ requesters.
- Each requester uses a valid/ready request handshake. The block registers the operands into the multiplier and tracks each request's ID through a tag pipeline matched to the multiplier latency.
- Products and their IDs are returned through a credit-protected response FIFO with a valid/ready handshake.
- Sits between client blocks and the shared multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 15, operand width.
- MUL_LAT, 2, fixed multiplier latency: cycles from mul_valid sampled to mul_p valid (1..4).
- FIFO_DEPTH, 4, response FIFO entries; must be >= MUL_LAT+2 for full throughput.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero, combinational.
- req_a  in  NUM_REQ*DATA_W  operand A, requester i at bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing as req_a.
- mul_valid  out  1  registered issue strobe to the multiplier.
- mul_a  out  DATA_W  registered operand A to the multiplier.
- mul_b  out  DATA_W  registered operand B to the multiplier.
- mul_p  in  2*DATA_W  multiplier product, valid MUL_LAT cycles after mul_valid.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  requester index of the head response.
- rsp_data  out  2*DATA_W  product at the FIFO head.

Behaviour:
- **Reset (rst=1 at a clock edge):**
  - mul_valid, mul_a, mul_b = 0.
  - Tag pipeline valid bits cleared; FIFO emptied (rsp_valid=0, rsp_id=0, rsp_data=0).
  - Outstanding counter = 0; round-robin pointer = 0.
  - Reset mid-operation discards all in-flight products. mul_p arriving afterwards is ignored because its tag valid bit is cleared.
- **Outstanding counter:**
  - Counts requests granted but not yet popped from the FIFO.
  - +1 on grant, -1 on pop (rsp_valid & rsp_ready); both in the same cycle leave it unchanged.
- **Pop definition:** pop = rsp_valid & rsp_ready.
- **Issue allowed:** (outstanding - pop) < FIFO_DEPTH.
  - A same-cycle pop frees a credit, so a combinational path rsp_ready -> req_ready exists by design.
- **Arbitration:**
  - When issue is allowed, grant the first requester with req_valid=1, searching from the pointer upward with wrap.
  - req_ready is asserted only for that requester.
  - A handshake is req_valid[i] & req_ready[i].
  - On a grant, the pointer moves to (granted index + 1) mod NUM_REQ. Otherwise it holds.
  - At most one grant per cycle; req_ready is all-zero when issue is not allowed.
- **Issue stage:** On a grant, the next edge sets mul_valid=1 and registers mul_a/mul_b from the granted requester. Without a grant, mul_valid=0 and mul_a/mul_b=0.
- **Tag pipeline:** A MUL_LAT-deep shift register carrying {valid, id}, loaded in step with mul_valid. When its output valid is 1, {id, mul_p} is written into the FIFO on that edge.
- **Latency:**
  - Grant in cycle N -> mul_valid in N+1 -> mul_p in N+1+MUL_LAT -> rsp_valid in N+2+MUL_LAT.
  - With MUL_LAT=2 this is 4 cycles.
- **Response FIFO:**
  - Synchronous, first-in first-out.
  - Simultaneous write and pop in the same cycle are both honoured.
  - Empty: rsp_valid=0, rsp_id/rsp_data hold their last values.
  - Full-write cannot occur because of the credit rule; an assertion flags it.
- **Throughput:** One product per cycle sustained when rsp_ready=1 and FIFO_DEPTH >= MUL_LAT+2.
- **Arithmetic:** Products are unsigned and full width (2*DATA_W). The scheduler never truncates.

Optional Feature:
- Macro: MULT_RR_SCHED_STATS_EN.
- With the macro defined:
  - Adds output stat_issue_cnt[31:0], incremented on every grant.
  - Adds output stat_stall_cnt[31:0], incremented each cycle in which |req_valid=1 and issue is not allowed.
  - Both counters saturate at all-ones and are cleared by rst.
- Without the macro: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- **Single request:** Reset, then req_valid[2]=1 with a=3, b=5 for one handshake, rsp_ready=1 -> mul_valid one cycle after the grant with mul_a=3, mul_b=5; rsp_valid 4 cycles after the grant with rsp_id=2, rsp_data=15.
- **Round robin:** All four requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1... with one grant per cycle and no bubbles; responses arrive in the same order with correct IDs.
- **Backpressure:** rsp_ready=0 with requester 0 valid -> exactly 4 grants, then req_ready=0; rsp_valid held. Raise rsp_ready -> one further grant occurs in the same cycle as the first pop.
- **Boundary operands:** a=b=0x7FFF -> rsp_data=0x3FFF0001. a=0, b=0x7FFF -> rsp_data=0.
- **Reset mid-flight:** Grant 3 requests, assert rst 2 cycles later for one cycle -> no rsp_valid afterwards, pointer=0, next grant goes to the lowest valid index.
- **Stats (with MULT_RR_SCHED_STATS_EN):** The backpressure scenario held 10 stalled cycles -> stat_issue_cnt=4, stat_stall_cnt=10 before rsp_ready is released.
